// File: rtl/read_data_collector.sv
// read_data_collector: receive side of the DFI read path.
// Pairs two PHY read-data beats into one word and routes the word by a tag.
// Each tag is queued when the read command is issued. A periodic-read word goes
// to the periodic response port. A host-read word goes to the read-back FIFO.
module read_data_collector #(
    parameter int DQ_WIDTH  = 64,
    parameter int TAG_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_issue,
    input  logic                           rd_issue_pr,
    input  logic                           dfi_rddata_valid,
    input  logic [4*DQ_WIDTH-1:0]          dfi_rddata,
    input  logic                           rdback_fifo_full,
    output logic                           rdback_fifo_wr,
    output logic [8*DQ_WIDTH-1:0]          rdback_fifo_data,
    output logic                           pr_rddata_valid,
    output logic [8*DQ_WIDTH-1:0]          pr_rddata,
    output logic [$clog2(TAG_DEPTH):0]     rd_outstanding,
    output logic                           err_overflow,
    output logic                           err_tag_full,
    output logic                           err_orphan
);

    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = 4 * DQ_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_t;

    state_t            state_q;
    logic              tag_q;        // 1 = periodic read, 0 = host read
    logic [BEAT_W-1:0] word_lo_q;

    logic              tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic tag_full;
    logic tag_empty;
    logic capture_first;
    logic push;
    logic pop;

    assign tag_full      = (count_q == CNT_W'(TAG_DEPTH));
    assign tag_empty     = (count_q == '0);
    assign capture_first = (state_q == IDLE) && dfi_rddata_valid;
    // A pop looks only at the registered count.
    // A tag pushed in this cycle cannot be popped in the same cycle.
    assign push          = rd_issue && !tag_full;
    assign pop           = capture_first && !tag_empty;
    assign rd_outstanding = count_q;

    // Next count of the tag queue. When a push and a pop happen together, the count does not change.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Tag storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= rd_issue_pr;
        end
    end

    // Tag queue pointers, tag queue count and the tag-overrun flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_tag_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            if (rd_issue && tag_full) begin
                err_tag_full <= 1'b1;
            end
        end
    end

    // Burst assembly FSM. It also drives the registered output strobes and the output data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            tag_q            <= 1'b0;
            word_lo_q        <= '0;
            rdback_fifo_wr   <= 1'b0;
            rdback_fifo_data <= '0;
            pr_rddata_valid  <= 1'b0;
            pr_rddata        <= '0;
            err_overflow     <= 1'b0;
            err_orphan       <= 1'b0;
        end else begin
            rdback_fifo_wr  <= 1'b0;
            pr_rddata_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dfi_rddata_valid) begin
                        word_lo_q <= dfi_rddata;
                        // If the queue is empty, treat the data as an orphaned host read.
                        tag_q     <= tag_empty ? 1'b0 : tag_mem[rd_ptr_q];
                        if (tag_empty) begin
                            err_orphan <= 1'b1;
                        end
                        state_q <= HALF;
                    end
                end
                HALF: begin
                    if (dfi_rddata_valid) begin
                        if (tag_q) begin
                            pr_rddata_valid <= 1'b1;
                            pr_rddata       <= {dfi_rddata, word_lo_q};
                        end else if (!rdback_fifo_full) begin
                            rdback_fifo_wr   <= 1'b1;
                            rdback_fifo_data <= {dfi_rddata, word_lo_q};
                        end else begin
                            err_overflow <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_data_collector.sv
// Testbench for read_data_collector.
// A reference model of the tag queue and beat pairing predicts each output word.
// A separate monitor pops the predicted words and compares them with the DUT outputs.
module tb_read_data_collector;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_issue = 1'b0;
    logic         rd_issue_pr = 1'b0;
    logic         dfi_rddata_valid = 1'b0;
    logic [255:0] dfi_rddata = '0;
    logic         rdback_fifo_full = 1'b0;
    logic         rdback_fifo_wr;
    logic [511:0] rdback_fifo_data;
    logic         pr_rddata_valid;
    logic [511:0] pr_rddata;
    logic [4:0]   rd_outstanding;
    logic         err_overflow;
    logic         err_tag_full;
    logic         err_orphan;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_pr;
        logic [511:0] data;
    } exp_t;

    exp_t         expq [$];
    bit           tagq [$];
    bit           m_half = 0;
    bit           m_tag = 0;
    logic [255:0] m_lo = '0;
    bit           m_ovf = 0;
    bit           m_tf = 0;
    bit           m_orph = 0;

    read_data_collector #(.DQ_WIDTH(64), .TAG_DEPTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_issue         (rd_issue),
        .rd_issue_pr      (rd_issue_pr),
        .dfi_rddata_valid (dfi_rddata_valid),
        .dfi_rddata       (dfi_rddata),
        .rdback_fifo_full (rdback_fifo_full),
        .rdback_fifo_wr   (rdback_fifo_wr),
        .rdback_fifo_data (rdback_fifo_data),
        .pr_rddata_valid  (pr_rddata_valid),
        .pr_rddata        (pr_rddata),
        .rd_outstanding   (rd_outstanding),
        .err_overflow     (err_overflow),
        .err_tag_full     (err_tag_full),
        .err_orphan       (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Reference model for one clock cycle, followed by the per-cycle status checks
    task automatic cyc(input bit iss, input bit pr, input bit v, input logic [255:0] d, input bit full);
        exp_t e;
        bit push_ok;
        @(negedge clk);
        rd_issue = iss; rd_issue_pr = pr; dfi_rddata_valid = v; dfi_rddata = d; rdback_fifo_full = full;
        push_ok = (tagq.size() < 16);
        if (v) begin
            if (!m_half) begin
                if (tagq.size() > 0) m_tag = tagq.pop_front();
                else begin m_tag = 0; m_orph = 1; end
                m_lo = d;
                m_half = 1;
            end else begin
                e.is_pr = m_tag;
                e.data = {d, m_lo};
                if (m_tag || !full) expq.push_back(e);
                else m_ovf = 1;
                m_half = 0;
            end
        end
        if (iss) begin
            if (push_ok) tagq.push_back(pr);
            else m_tf = 1;
        end
        @(posedge clk);
        #1;
        check("rd_outstanding", 512'(rd_outstanding), 512'(tagq.size()));
        check("err_overflow", 512'(err_overflow), 512'(m_ovf));
        check("err_tag_full", 512'(err_tag_full), 512'(m_tf));
        check("err_orphan", 512'(err_orphan), 512'(m_orph));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        idle(3);
        @(negedge clk);
        rst_n = 0;
        rd_issue = 0; dfi_rddata_valid = 0; rdback_fifo_full = 0;
        tagq.delete(); m_half = 0; m_ovf = 0; m_tf = 0; m_orph = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", 512'(rdback_fifo_wr), 512'(0));
        check("rst_pr_valid", 512'(pr_rddata_valid), 512'(0));
        check("rst_rb_data", rdback_fifo_data, 512'(0));
        check("rst_pr_data", pr_rddata, 512'(0));
        check("rst_outstanding", 512'(rd_outstanding), 512'(0));
        check("rst_errs", 512'({err_overflow, err_tag_full, err_orphan}), 512'(0));
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: each output strobe consumes the oldest predicted word
    always @(negedge clk) begin
        exp_t e;
        bit got_pr;
        logic [511:0] got;
        if (rst_n && (rdback_fifo_wr || pr_rddata_valid)) begin
            if (rdback_fifo_wr && pr_rddata_valid) begin
                checks++; errors++;
                $display("FAIL dual_strobe got=both want=one");
            end
            got_pr = pr_rddata_valid;
            got = got_pr ? pr_rddata : rdback_fifo_data;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got pr=%0d data=%0h want=none", got_pr, got);
            end else begin
                e = expq.pop_front();
                $display("word pr=%0d data=%0h", got_pr, got);
                if (e.is_pr != got_pr || e.data !== got) begin
                    errors++;
                    $display("FAIL word got pr=%0d %0h want pr=%0d %0h", got_pr, got, e.is_pr, e.data);
                end
            end
        end
    end

    initial begin
        logic [255:0] a, b;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: single host read, data returns later as A then B
        a = rand_beat(); b = rand_beat();
        cyc(1, 0, 0, '0, 0);
        idle(8);
        cyc(0, 0, 1, a, 0);
        cyc(0, 0, 1, b, 0);
        idle(2);

        // 2: a periodic read, then a host read, with back-to-back bursts
        cyc(1, 1, 0, '0, 0);
        cyc(1, 0, 0, '0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, rand_beat(), 0);
        idle(2);

        // 3: overrun the tag queue, then drain it
        for (int i = 0; i < 17; i++) cyc(1, $urandom_range(0, 1), 0, '0, 0);
        check("outstanding_16", 512'(rd_outstanding), 512'(16));
        check("tag_full_set", 512'(err_tag_full), 512'(1));
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, rand_beat(), 0);
        idle(2);

        // 4: read data arrives with no tag queued
        cyc(0, 0, 1, rand_beat(), 0);
        cyc(0, 0, 1, rand_beat(), 0);
        check("orphan_set", 512'(err_orphan), 512'(1));
        idle(2);

        // 5: FIFO is full on the second half; the next read is still delivered
        cyc(1, 0, 0, '0, 0);
        cyc(1, 0, 0, '0, 0);
        cyc(0, 0, 1, rand_beat(), 0);
        cyc(0, 0, 1, rand_beat(), 1);
        cyc(0, 0, 1, rand_beat(), 0);
        cyc(0, 0, 1, rand_beat(), 0);
        idle(2);

        // 6: reset between the two halves of a burst, then a fresh read
        cyc(1, 0, 0, '0, 0);
        cyc(0, 0, 1, rand_beat(), 0);
        do_reset();
        cyc(1, 1, 0, '0, 0);
        cyc(0, 0, 1, rand_beat(), 0);
        cyc(0, 0, 1, rand_beat(), 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                rand_beat(), $urandom_range(0, 4) == 0);
        idle(5);
        check("all_words_seen", 512'(expq.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
